// File: rtl/reset_release_sequencer_if.sv
// Control/status bundle between the reset-release sequencer and its surroundings.
// The sequencer attaches through the slave modport; the driver of its inputs uses master.
interface reset_release_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   PLL_LOCK;
    logic                   INIT_DONE;
    logic                   SW_RST_REQ;
    logic [NUM_DOMAINS-1:0] DOMAIN_READY;
    logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N;
    logic                   SEQ_DONE;
    logic                   SEQ_FAULT;
    logic [2:0]             FAULT_DOMAIN;
    logic [2:0]             STAGE;

    modport master (
        output PLL_LOCK, INIT_DONE, SW_RST_REQ, DOMAIN_READY,
        input  DOMAIN_RESET_N, SEQ_DONE, SEQ_FAULT, FAULT_DOMAIN, STAGE
    );

    modport slave (
        input  PLL_LOCK, INIT_DONE, SW_RST_REQ, DOMAIN_READY,
        output DOMAIN_RESET_N, SEQ_DONE, SEQ_FAULT, FAULT_DOMAIN, STAGE
    );
endinterface

// File: rtl/reset_release_sequencer.sv
// Releases NUM_DOMAINS domain resets one at a time after PLL lock and init, with ack timeout.
// Optional macro RESET_SEQ_LOCK_LOSS_EN: loss of PLL lock after HOLD restarts the sequence.
module reset_release_sequencer #(
    parameter int NUM_DOMAINS   = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int READY_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input logic                       CLK,
    input logic                       EXT_RST_N,
    reset_release_sequencer_if.slave  bus
);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [2:0]       LAST_STAGE = 3'(NUM_DOMAINS - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(READY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_SETTLE,
        S_WAIT_ACK,
        S_DONE,
        S_FAULT
    } state_t;

    logic [NUM_DOMAINS+1:0] raw_in;
    logic [NUM_DOMAINS+1:0] meta_reg;
    logic [NUM_DOMAINS+1:0] sync_reg;
    logic                   pll_sync;
    logic                   init_sync;
    logic [NUM_DOMAINS-1:0] ready_sync;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next, cnt_sat;
    logic [2:0]             stage_reg, stage_next;
    logic [NUM_DOMAINS-1:0] rst_n_reg, rst_n_next;
    logic                   done_reg, done_next;
    logic                   fault_reg, fault_next;
    logic [2:0]             fdom_reg, fdom_next;
    logic [IDX_W-1:0]       stage_idx;
    logic                   lock_lost;

    assign raw_in     = {bus.PLL_LOCK, bus.INIT_DONE, bus.DOMAIN_READY};
    assign pll_sync   = sync_reg[NUM_DOMAINS+1];
    assign init_sync  = sync_reg[NUM_DOMAINS];
    assign ready_sync = sync_reg[NUM_DOMAINS-1:0];

    always_ff @(posedge CLK or negedge EXT_RST_N) begin
        if (!EXT_RST_N) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= raw_in;
            sync_reg <= meta_reg;
        end
    end

    // STAGE never exceeds NUM_DOMAINS-1, so the low bits are a safe domain index.
    assign stage_idx = stage_reg[IDX_W-1:0];
    assign cnt_sat   = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

`ifdef RESET_SEQ_LOCK_LOSS_EN
    assign lock_lost = !pll_sync &&
                       (state_reg == S_SETTLE || state_reg == S_WAIT_ACK || state_reg == S_DONE);
`else
    assign lock_lost = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stage_next = stage_reg;
        rst_n_next = rst_n_reg;
        done_next  = done_reg;
        fault_next = fault_reg;
        fdom_next  = fdom_reg;

        if (bus.SW_RST_REQ) begin
            state_next = S_HOLD;
            cnt_next   = '0;
            stage_next = '0;
            rst_n_next = '0;
            done_next  = 1'b0;
            if (state_reg == S_DONE || state_reg == S_FAULT) begin
                fault_next = 1'b0;
                fdom_next  = '0;
            end
        end else if (lock_lost) begin
            state_next = S_HOLD;
            cnt_next   = '0;
            stage_next = '0;
            rst_n_next = '0;
            done_next  = 1'b0;
        end else begin
            case (state_reg)
                S_HOLD: begin
                    cnt_next   = '0;
                    stage_next = '0;
                    rst_n_next = '0;
                    if (pll_sync && init_sync) begin
                        state_next = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_reg == SETTLE_END) begin
                        rst_n_next[stage_idx] = 1'b1;
                        cnt_next   = '0;
                        state_next = S_WAIT_ACK;
                    end else begin
                        cnt_next = cnt_sat;
                    end
                end
                S_WAIT_ACK: begin
                    // An ack arriving on the timeout cycle wins over the timeout.
                    if (ready_sync[stage_idx]) begin
                        if (stage_reg == LAST_STAGE) begin
                            state_next = S_DONE;
                            done_next  = 1'b1;
                        end else begin
                            stage_next = stage_reg + 3'd1;
                            cnt_next   = '0;
                            state_next = S_SETTLE;
                        end
                    end else if (cnt_reg == TIMEOUT_END) begin
                        state_next            = S_FAULT;
                        fault_next            = 1'b1;
                        fdom_next             = stage_reg;
                        rst_n_next[stage_idx] = 1'b0;
                    end else begin
                        cnt_next = cnt_sat;
                    end
                end
                S_DONE, S_FAULT: begin
                    state_next = state_reg;
                end
                default: begin
                    state_next = S_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge EXT_RST_N) begin
        if (!EXT_RST_N) begin
            state_reg <= S_HOLD;
            cnt_reg   <= '0;
            stage_reg <= '0;
            rst_n_reg <= '0;
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
            fdom_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            stage_reg <= stage_next;
            rst_n_reg <= rst_n_next;
            done_reg  <= done_next;
            fault_reg <= fault_next;
            fdom_reg  <= fdom_next;
        end
    end

    assign bus.DOMAIN_RESET_N = rst_n_reg;
    assign bus.SEQ_DONE       = done_reg;
    assign bus.SEQ_FAULT      = fault_reg;
    assign bus.FAULT_DOMAIN   = fdom_reg;
    assign bus.STAGE          = stage_reg;
endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: directed scenarios plus random traffic, every cycle
// compared against a deadline-based behavioural model of the release sequence.
module tb_reset_release_sequencer;
    localparam int N       = 4;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1024;
`ifdef RESET_SEQ_LOCK_LOSS_EN
    localparam bit LOCK_LOSS = 1'b1;
`else
    localparam bit LOCK_LOSS = 1'b0;
`endif
    localparam int PH_IDLE = 0, PH_COUNTDOWN = 1, PH_AWAIT = 2, PH_COMPLETE = 3, PH_STUCK = 4;

    logic clk;
    logic rst_n;

    reset_release_sequencer_if #(.NUM_DOMAINS(N)) bus ();

    reset_release_sequencer #(
        .NUM_DOMAINS(N), .SETTLE_CYCLES(SETTLE), .READY_TIMEOUT(TIMEOUT), .CNT_W(16)
    ) dut (
        .CLK(clk),
        .EXT_RST_N(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;

    // Reference model: phase, current stage and an absolute deadline cycle.
    int         m_phase, m_stage, m_deadline, m_fdom;
    logic [N-1:0] m_rel;
    bit         m_done, m_fault;
    bit         q1_pll, q2_pll, q1_init, q2_init;
    logic [N-1:0] q1_rdy, q2_rdy;

    int         dly [N];
    int         age [N];
    logic [N-1:0] force_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE; m_stage = 0; m_deadline = 0; m_fdom = 0;
        m_rel = '0; m_done = 0; m_fault = 0;
        q1_pll = 0; q2_pll = 0; q1_init = 0; q2_init = 0; q1_rdy = '0; q2_rdy = '0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (bus.SW_RST_REQ) begin
            if (m_phase == PH_COMPLETE || m_phase == PH_STUCK) begin
                m_fault = 0; m_fdom = 0;
            end
            m_phase = PH_IDLE; m_rel = '0; m_done = 0; m_stage = 0;
        end else if (LOCK_LOSS && !q2_pll &&
                     (m_phase == PH_COUNTDOWN || m_phase == PH_AWAIT || m_phase == PH_COMPLETE)) begin
            m_phase = PH_IDLE; m_rel = '0; m_done = 0; m_stage = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (q2_pll && q2_init) begin
                    m_phase = PH_COUNTDOWN; m_deadline = cyc + SETTLE;
                end
                PH_COUNTDOWN: if (cyc == m_deadline) begin
                    m_rel[m_stage] = 1'b1; m_phase = PH_AWAIT; m_deadline = cyc + TIMEOUT;
                end
                PH_AWAIT: begin
                    if (q2_rdy[m_stage]) begin
                        if (m_stage == N - 1) begin
                            m_phase = PH_COMPLETE; m_done = 1;
                        end else begin
                            m_stage++; m_phase = PH_COUNTDOWN; m_deadline = cyc + SETTLE;
                        end
                    end else if (cyc == m_deadline) begin
                        m_phase = PH_STUCK; m_fault = 1; m_fdom = m_stage; m_rel[m_stage] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        q2_pll = q1_pll; q1_pll = bus.PLL_LOCK;
        q2_init = q1_init; q1_init = bus.INIT_DONE;
        q2_rdy = q1_rdy; q1_rdy = bus.DOMAIN_READY;
    endtask

    task automatic compare_all();
        check("domain_reset_n", 32'(bus.DOMAIN_RESET_N), 32'(m_rel));
        check("seq_done", 32'(bus.SEQ_DONE), 32'(m_done));
        check("seq_fault", 32'(bus.SEQ_FAULT), 32'(m_fault));
        check("fault_domain", 32'(bus.FAULT_DOMAIN), 32'(m_fdom));
        check("stage", 32'(bus.STAGE), 32'(m_stage));
    endtask

    // Each domain acks dly[i] cycles after the model releases it, plus forced bits.
    task automatic drive_ready();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            age[i] = m_rel[i] ? age[i] + 1 : 0;
            r[i] = (age[i] > dly[i]) || force_rdy[i];
        end
        bus.DOMAIN_READY = r;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_all();
        drive_ready();
    endtask

    task automatic run_to(input int rel_cycle);
        while (cyc - t0 < rel_cycle) step();
    endtask

    task automatic sw_pulse();
        bus.SW_RST_REQ = 1'b1;
        step();
        bus.SW_RST_REQ = 1'b0;
    endtask

    task automatic restart();
        rst_n = 1'b0;
        model_reset();
        bus.PLL_LOCK = 1'b0; bus.INIT_DONE = 1'b0; bus.SW_RST_REQ = 1'b0;
        force_rdy = '0;
        for (int i = 0; i < N; i++) age[i] = 0;
        bus.DOMAIN_READY = '0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        bus.PLL_LOCK = 1'b1; bus.INIT_DONE = 1'b1;
        t0 = cyc;
    endtask

    initial begin
        bit reached;
        int tl;
        rst_n = 1'b0;
        bus.PLL_LOCK = 1'b0; bus.INIT_DONE = 1'b0; bus.SW_RST_REQ = 1'b0; bus.DOMAIN_READY = '0;
        force_rdy = '0;
        for (int i = 0; i < N; i++) begin dly[i] = 3; age[i] = 0; end
        model_reset();

        // Nominal sequence
        restart();
        check("reset_state_rel", 32'(bus.DOMAIN_RESET_N), 32'h0);
        run_to(18); check("nom_rel_before", 32'(bus.DOMAIN_RESET_N), 32'h0);
        run_to(19); check("nom_rel0", 32'(bus.DOMAIN_RESET_N), 32'h1);
        run_to(40); check("nom_rel0_hold", 32'(bus.DOMAIN_RESET_N), 32'h1);
        run_to(41); check("nom_rel1", 32'(bus.DOMAIN_RESET_N), 32'h3);
        run_to(63); check("nom_rel2", 32'(bus.DOMAIN_RESET_N), 32'h7);
        run_to(85); check("nom_rel3", 32'(bus.DOMAIN_RESET_N), 32'hF);
        run_to(90); check("nom_done_early", 32'(bus.SEQ_DONE), 32'h0);
        run_to(91); check("nom_done", 32'(bus.SEQ_DONE), 32'h1);
        check("nom_stage", 32'(bus.STAGE), 32'h3);

        // Lock loss while DONE
        bus.PLL_LOCK = 1'b0; tl = cyc;
        step(); step();
        check("ll_rel_pre", 32'(bus.DOMAIN_RESET_N), 32'hF);
        step();
        check("ll_rel_after", 32'(bus.DOMAIN_RESET_N), LOCK_LOSS ? 32'h0 : 32'hF);
        repeat (4) step();
        bus.PLL_LOCK = 1'b1;
        reached = 0;
        for (int k = 0; k < 300 && !reached; k++) begin step(); reached = m_done; end
        check("ll_resequence_reached", 32'(reached), 32'h1);
        check("ll_rel_final", 32'(bus.DOMAIN_RESET_N), 32'hF);

        // Domain 2 never acks
        dly[2] = 100000;
        restart();
        run_to(1086); check("to_fault_early", 32'(bus.SEQ_FAULT), 32'h0);
        run_to(1087); check("to_fault", 32'(bus.SEQ_FAULT), 32'h1);
        check("to_fault_domain", 32'(bus.FAULT_DOMAIN), 32'h2);
        check("to_rel", 32'(bus.DOMAIN_RESET_N), 32'h3);
        repeat (5) step();
        check("to_sticky", 32'(bus.SEQ_FAULT), 32'h1);
        sw_pulse();
        check("to_sw_clear_fault", 32'(bus.SEQ_FAULT), 32'h0);
        check("to_sw_clear_rel", 32'(bus.DOMAIN_RESET_N), 32'h0);

        // Ack lands exactly on the timeout cycle of domain 1
        dly[1] = 1021; dly[2] = 3;
        restart();
        run_to(1064); check("race_stage_pre", 32'(bus.STAGE), 32'h1);
        run_to(1065); check("race_stage", 32'(bus.STAGE), 32'h2);
        check("race_no_fault", 32'(bus.SEQ_FAULT), 32'h0);
        dly[1] = 3;

        // Software restart while stage 2 is active
        restart();
        reached = 0;
        for (int k = 0; k < 200 && !reached; k++) begin step(); reached = (m_stage == 2); end
        check("sw_reach_stage2", 32'(reached), 32'h1);
        sw_pulse();
        check("sw_rel", 32'(bus.DOMAIN_RESET_N), 32'h0);
        check("sw_stage", 32'(bus.STAGE), 32'h0);
        reached = 0;
        for (int k = 0; k < 300 && !reached; k++) begin step(); reached = m_done; end
        check("sw_reseq_done", 32'(reached), 32'h1);
        check("sw_reseq_rel", 32'(bus.DOMAIN_RESET_N), 32'hF);

        // Asynchronous reset while waiting for an ack
        dly[1] = 50;
        restart();
        reached = 0;
        for (int k = 0; k < 200 && !reached; k++) begin step(); reached = (m_stage == 1 && m_rel[1]); end
        check("ar_reach_wait", 32'(reached), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar_rel", 32'(bus.DOMAIN_RESET_N), 32'h0);
        check("ar_stage", 32'(bus.STAGE), 32'h0);
        check("ar_done", 32'(bus.SEQ_DONE), 32'h0);
        repeat (2) step();
        dly[1] = 3;

        // Ack from a domain other than the current stage is ignored
        dly[0] = 30;
        force_rdy = 4'b1000;
        rst_n = 1'b1;
        reached = 0;
        for (int k = 0; k < 100 && !reached; k++) begin step(); reached = m_rel[0]; end
        check("ws_rel0", 32'(reached), 32'h1);
        repeat (20) step();
        check("ws_stage_hold", 32'(bus.STAGE), 32'h0);
        reached = 0;
        for (int k = 0; k < 100 && !reached; k++) begin step(); reached = (m_stage == 1); end
        check("ws_stage_adv", 32'(reached), 32'h1);
        force_rdy = '0;
        dly[0] = 3;

        // Random traffic: ack delays, stray acks, software restarts and lock drops
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++)
                dly[i] = ($urandom_range(0, 9) == 0) ? 1100 : int'($urandom_range(0, 40));
            restart();
            for (int k = 0; k < 1600; k++) begin
                if ($urandom_range(0, 249) == 0) bus.SW_RST_REQ = 1'b1;
                if (bus.PLL_LOCK && $urandom_range(0, 399) == 0) bus.PLL_LOCK = 1'b0;
                else if (!bus.PLL_LOCK && $urandom_range(0, 19) == 0) bus.PLL_LOCK = 1'b1;
                if ($urandom_range(0, 49) == 0) force_rdy = N'($urandom);
                else if ($urandom_range(0, 9) == 0) force_rdy = '0;
                step();
                bus.SW_RST_REQ = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
